// File: rtl/reg_writeback.sv
// reg_writeback: write-side controller for the integer register file.
// Merges single-cycle ALU results and queued long-latency (LSU/MUL) results
// onto the single register-file write port, and tracks pending long-latency
// destinations so the issue stage can stall on RAW hazards.
//
// Optional build macro: MSPU_WB_BYPASS_EN
//   defined   - pending clears on the edge the queued result reaches reg_we,
//               and the registered write is forwarded onto rdata_a/rdata_b.
//   undefined - pending clears one edge later, when the register file has
//               committed the write; read data passes straight through.

module reg_writeback #(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int AW       = 5,
    parameter int LQ_DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            run,
    input  logic            alu_valid,
    input  logic [AW-1:0]   alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  logic [AW-1:0]   lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rd,
    input  logic [AW-1:0]   raddr_a,
    input  logic [AW-1:0]   raddr_b,
    input  logic [XLEN-1:0] rf_rdata_a,
    input  logic [XLEN-1:0] rf_rdata_b,
    output logic [XLEN-1:0] rdata_a,
    output logic [XLEN-1:0] rdata_b,
    output logic            stall_a,
    output logic            stall_b,
    output logic [NREG-1:0] pending,
    output logic            reg_we,
    output logic [AW-1:0]   waddr,
    output logic [XLEN-1:0] wdata
);

    localparam int PW = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(LQ_DEPTH);

    // Long-latency result queue
    logic [AW-1:0]   q_rd   [LQ_DEPTH];
    logic [XLEN-1:0] q_data [LQ_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;

    logic            q_full;
    logic            q_empty;
    logic            push;
    logic            pop;
    logic            alu_wr;
    logic [AW-1:0]   head_rd;
    logic [XLEN-1:0] head_data;

    // Scoreboard update terms
    logic            set_v;
    logic            clr_v;
    logic [AW-1:0]   clr_rd;
    logic [NREG-1:0] pending_nxt;

`ifndef MSPU_WB_BYPASS_EN
    // Last queued write sent to the register file; its commit edge is the
    // next run edge, which is when the pending bit may safely drop.
    logic            last_v;
    logic [AW-1:0]   last_rd;
`endif

    assign q_full    = (count == FULL_CNT);
    assign q_empty   = (count == '0);
    assign head_rd   = q_rd[rd_ptr];
    assign head_data = q_data[rd_ptr];

    // A freed slot only becomes visible after the pop edge, so a full queue
    // refuses a push even in a cycle where it is also popping.
    assign lsu_ready = run && reset && !q_full;
    assign push      = lsu_valid && lsu_ready;

    // rd==0 ALU results are dropped and leave the port free for the queue.
    assign alu_wr    = alu_valid && (alu_rd != '0);
    assign pop       = run && !alu_wr && !q_empty;

    assign set_v     = run && issue_valid && (issue_rd != '0);

`ifdef MSPU_WB_BYPASS_EN
    assign clr_v  = pop && (head_rd != '0);
    assign clr_rd = head_rd;
`else
    assign clr_v  = last_v;
    assign clr_rd = last_rd;
`endif

    // Next scoreboard value: clear first so a same-edge set of the same rd wins.
    always_comb begin
        pending_nxt = pending;
        if (clr_v) begin
            pending_nxt[clr_rd] = 1'b0;
        end
        if (set_v) begin
            pending_nxt[issue_rd] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    // Queue storage; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            q_rd[wr_ptr]   <= lsu_rd;
            q_data[wr_ptr] <= lsu_data;
        end
    end

    // Queue pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (run) begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Write-port arbitration: ALU first, then the queue head; port holds while frozen.
    always_ff @(posedge clk) begin
        if (!reset) begin
            reg_we <= 1'b0;
            waddr  <= '0;
            wdata  <= '0;
        end else if (run) begin
            if (alu_wr) begin
                reg_we <= 1'b1;
                waddr  <= alu_rd;
                wdata  <= alu_data;
            end else if (pop) begin
                reg_we <= (head_rd != '0);
                waddr  <= head_rd;
                wdata  <= head_data;
            end else begin
                reg_we <= 1'b0;
            end
        end
    end

`ifndef MSPU_WB_BYPASS_EN
    // Remember the queued write just issued so its commit edge can clear pending.
    always_ff @(posedge clk) begin
        if (!reset) begin
            last_v  <= 1'b0;
            last_rd <= '0;
        end else if (run) begin
            last_v  <= pop && (head_rd != '0);
            last_rd <= head_rd;
        end
    end
`endif

    // Pending scoreboard register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pending <= '0;
        end else if (run) begin
            pending <= pending_nxt;
        end
    end

    assign stall_a = pending[raddr_a];
    assign stall_b = pending[raddr_b];

`ifdef MSPU_WB_BYPASS_EN
    // Forward the registered write during the cycle before the file commits it.
    always_comb begin
        rdata_a = rf_rdata_a;
        rdata_b = rf_rdata_b;
        if (reg_we && (waddr == raddr_a) && (raddr_a != '0)) begin
            rdata_a = wdata;
        end
        if (reg_we && (waddr == raddr_b) && (raddr_b != '0)) begin
            rdata_b = wdata;
        end
    end
`else
    assign rdata_a = rf_rdata_a;
    assign rdata_b = rf_rdata_b;
`endif

`ifndef SYNTHESIS
    // A second long-latency op to a destination still in flight is an issue-stage bug,
    // unless that destination is being cleared on this very edge.
    a_no_double_issue: assert property (@(posedge clk) disable iff (!reset)
        (run && issue_valid && (issue_rd != '0))
            |-> (!pending[issue_rd] || (clr_v && (clr_rd == issue_rd))));
`endif

endmodule

// File: doc/reg_writeback.md
Name: reg_writeback

Overview:
- Write-side controller for the 32-entry integer register file.
- Merges single-cycle ALU results with long-latency LSU/MUL results into the file's single write port (reg_we/waddr/wdata).
- Keeps a per-register pending scoreboard so the issue stage can stall on RAW hazards.
- Sits between the execute/memory units and the register file; read data optionally bypassed back to decode.

Parameters:
XLEN, 32, data width
NREG, 32, number of architectural registers
AW, 5, register address width (log2 NREG)
LQ_DEPTH, 2, long-latency result queue depth (power of 2, >=2)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low
run  in  1  global enable; 0 freezes all state
alu_valid  in  1  ALU result present this cycle (no backpressure)
alu_rd  in  AW  ALU destination
alu_data  in  XLEN  ALU result
lsu_valid  in  1  long-latency result valid
lsu_ready  out  1  queue can accept a result
lsu_rd  in  AW  long-latency destination
lsu_data  in  XLEN  long-latency result
issue_valid  in  1  long-latency op issued this cycle
issue_rd  in  AW  its destination (marks pending)
raddr_a, raddr_b  in  AW  decode read addresses
rf_rdata_a, rf_rdata_b  in  XLEN  register file read data
rdata_a, rdata_b  out  XLEN  read data to decode
stall_a, stall_b  out  1  read address has pending write
pending  out  NREG  scoreboard bitmask
reg_we  out  1  to register file
waddr  out  AW  to register file
wdata  out  XLEN  to register file

Behaviour:
- Reset (reset==0 at posedge): reg_we=0, waddr=0, wdata=0, queue empty, pending=0. lsu_ready=0 while reset==0; 1 in the first cycle after release.
- run==0: no state changes, lsu_ready=0, ALU input ignored, reg_we/waddr/wdata hold.
- Queue push: lsu_valid && lsu_ready at posedge. lsu_ready = run && reset && !full. Push while full is impossible by construction.
- Write arbitration, each run cycle:
  - Priority 1: alu_valid && alu_rd!=0 → register {1, alu_rd, alu_data}.
  - Priority 2: otherwise, if queue non-empty, pop head → register {head_rd!=0, head_rd, head_data}.
  - Otherwise: reg_we=0.
- Latency: input to reg_we high is 1 cycle; register file commit follows at the next edge.
- alu_rd==0: treated as no ALU write; the queue may drain that cycle.
- Popped entry with rd==0: discarded, reg_we=0, pending unaffected.
- Push and pop in the same cycle are allowed, including at full (pop frees the slot only at the edge; lsu_ready is still 0 that cycle) and at empty (no fall-through; pushed entry pops next cycle at earliest).
- Pointers wrap modulo LQ_DEPTH; count held in log2(LQ_DEPTH)+1 bits.
- Scoreboard:
  - Set: pending[issue_rd] set when issue_valid && issue_rd!=0.
  - Clear: on LSU-sourced write completion (timing per Optional Feature).
  - Set and clear of the same rd on the same edge: set wins.
  - pending[0] is always 0.
  - Issuing to an already-pending rd is illegal: simulation assertion fires; RTL leaves the bit at 1.
- ALU writes never touch pending.
- stall_x = pending[raddr_x], combinational. raddr_x==0 → stall_x=0.

Optional Feature:
- Macro: MSPU_WB_BYPASS_EN.
- Defined:
  - pending clears at the pop edge, i.e. the edge where reg_we goes high for that entry.
  - rdata_x = wdata when reg_we && waddr==raddr_x && raddr_x!=0; else rf_rdata_x.
  - Covers the cycle before the register file commits.
- Undefined:
  - rdata_x = rf_rdata_x.
  - pending clears one edge later (commit edge), tracked by a 1-deep registered {valid, rd} of the last LSU write.
  - Set-wins rule still applies against this delayed clear.

Test Plan:
- Reset then idle → reg_we=0, pending=0, lsu_ready=1 after release; reset asserted mid-drain with 2 queued → queue empty, reg_we=0 next cycle.
- alu_valid=1, rd=5, data=0x1234 → next cycle reg_we=1, waddr=5, wdata=0x1234; alu_rd=0 → reg_we=0.
- issue rd=7; LSU returns rd=7, 0xDEAD while ALU writes rd=3 each cycle for 3 cycles → ALU writes first, LSU write lands on cycle 4, stall for raddr_a=7 stays 1 until the clear edge (pop edge with bypass, +1 without).
- Fill queue with 2 LSU results under continuous ALU traffic → lsu_ready=0; stop ALU → entries written in FIFO order, lsu_ready=1 after first pop.
- run=0 for 3 cycles with reg_we=1, waddr=9 → outputs hold, no push/pop, lsu_ready=0; run=1 resumes unchanged.
- MSPU_WB_BYPASS_EN: reg_we=1, waddr=4, wdata=0xCAFE, raddr_b=4, rf_rdata_b=0 → rdata_b=0xCAFE same cycle; without macro rdata_b=0 and stall_b=1.
